alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: the core datapath (port 0) and an auxiliary address/immediate unit (port 1). Each requester issues one operation per transaction over a valid/ready handshake. The block arbitrates between them, registers the operands, executes on the ALU, and returns a registered result tagged with the requester ID. It sits between the requesters and the ALU instance, which it owns.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter_alu.sv | 30 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, FSM encoding, bus width and payload structs.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  // Operand/result width; the ALU is fixed at 32 bits.
  localparam int DATA_WIDTH = 32;

  // ALU opcodes. Only LUI and ORI are implemented by the ALU today.
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_ORI  = 4'b1001;
  localparam logic [3:0] OP_ADDI = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLLI = 4'b1100;
  localparam logic [3:0] OP_SRLI = 4'b0011;

  // Arbiter FSM encoding (2'd3 is unused and recovers to IDLE).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Captured request: requester id, opcode and operands.
  typedef struct packed {
    logic                  id;
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } op_t;

  // Registered response payload.
  typedef struct packed {
    logic                  id;
    logic                  zero;
    logic [DATA_WIDTH-1:0] result;
  } rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters, the result consumer and alu_arbiter.
// Latency: wires only.
// Backpressure: valid/ready on each request port and on the response.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
);

  // Port 0: core datapath
  logic                  Req0_Valid_i;
  logic                  Req0_Ready_o;
  logic [3:0]            Req0_ALU_Operation_i;
  logic [DATA_WIDTH-1:0] Req0_A_i;
  logic [DATA_WIDTH-1:0] Req0_B_i;

  // Port 1: auxiliary address/immediate unit
  logic                  Req1_Valid_i;
  logic                  Req1_Ready_o;
  logic [3:0]            Req1_ALU_Operation_i;
  logic [DATA_WIDTH-1:0] Req1_A_i;
  logic [DATA_WIDTH-1:0] Req1_B_i;

  // Response to the consumer
  logic                  Resp_Valid_o;
  logic                  Resp_Ready_i;
  logic                  Resp_Id_o;
  logic [DATA_WIDTH-1:0] Resp_Result_o;
  logic                  Resp_Zero_o;

  logic                  Busy_o;

  // Arbiter side
  modport slave (
    input  Req0_Valid_i, Req0_ALU_Operation_i, Req0_A_i, Req0_B_i,
    output Req0_Ready_o,
    input  Req1_Valid_i, Req1_ALU_Operation_i, Req1_A_i, Req1_B_i,
    output Req1_Ready_o,
    output Resp_Valid_o, Resp_Id_o, Resp_Result_o, Resp_Zero_o,
    input  Resp_Ready_i,
    output Busy_o
  );

  // Requester/consumer side
  modport master (
    output Req0_Valid_i, Req0_ALU_Operation_i, Req0_A_i, Req0_B_i,
    input  Req0_Ready_o,
    output Req1_Valid_i, Req1_ALU_Operation_i, Req1_A_i, Req1_B_i,
    input  Req1_Ready_o,
    input  Resp_Valid_o, Resp_Id_o, Resp_Result_o, Resp_Zero_o,
    output Resp_Ready_i,
    input  Busy_o
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Existing 32-bit combinational ALU: LUI and ORI implemented, every other opcode yields 0.
// Latency: purely combinational.
// Backpressure: none.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [3:0]         ALU_Operation_i,
  input  logic signed [31:0] A_i,
  input  logic signed [31:0] B_i,
  output logic [31:0]        ALU_Result_o,
  output logic               Zero_o
);

  // Opcode decode; the unimplemented opcodes are listed so they stay visibly zero-result.
  always_comb begin
    ALU_Result_o = 32'd0;
    case (ALU_Operation_i)
      OP_LUI:  ALU_Result_o = {B_i[19:0], 12'b0};
      OP_ORI:  ALU_Result_o = A_i | B_i;
      OP_ADDI,
      OP_SUB,
      OP_SLLI,
      OP_SRLI: ALU_Result_o = 32'd0;
      default: ALU_Result_o = 32'd0;
    endcase
  end

  assign Zero_o = (ALU_Result_o == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared ALU: accept one op, register operands, execute, return a tagged result.
// Latency: accepted in cycle N, result valid in cycle N+2; one op per 3 cycles, no overlap.
// Backpressure: result held in RESP until Resp_Ready_i; both request Readys stay low outside IDLE.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin on contention, otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  import alu_pkg::*;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  idle;
  logic                  grant_id;
  logic                  ready0;
  logic                  ready1;
  logic                  accept;
  op_t                   opnd;
  rsp_t                  rsp;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic rr_ptr;
`endif

  assign idle = (state == ST_IDLE);

  // Pick a winner from the valids; contention resolves by pointer or fixed port-0 priority.
  always_comb begin
    grant_id = 1'b0;
    if (bus.Req0_Valid_i && bus.Req1_Valid_i) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant_id = rr_ptr;
`else
      grant_id = 1'b0;
`endif
    end else begin
      grant_id = bus.Req1_Valid_i;
    end
  end

  // Ready only in IDLE and only to the granted port; never looks at the response side.
  assign ready0 = idle && bus.Req0_Valid_i && !grant_id;
  assign ready1 = idle && bus.Req1_Valid_i &&  grant_id;
  assign accept = ready0 || ready1;

  assign bus.Req0_Ready_o = ready0;
  assign bus.Req1_Ready_o = ready1;

  // Next-state: accept -> execute -> hold response until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.Resp_Ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight op, even one completing its handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Pointer moves to the losing side on every acceptance so a waiting port wins next time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= !grant_id;
    end
  end
`endif

  // Capture the granted request's payload; opcode passes through untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      opnd <= '0;
    end else if (accept) begin
      opnd.id <= grant_id;
      opnd.op <= grant_id ? bus.Req1_ALU_Operation_i : bus.Req0_ALU_Operation_i;
      opnd.a  <= grant_id ? bus.Req1_A_i : bus.Req0_A_i;
      opnd.b  <= grant_id ? bus.Req1_B_i : bus.Req0_B_i;
    end
  end

  alu_arbiter_alu u_alu (
    .ALU_Operation_i (opnd.op),
    .A_i             (opnd.a),
    .B_i             (opnd.b),
    .ALU_Result_o    (alu_result),
    .Zero_o          (alu_zero)
  );

  // Register the ALU output on the EXEC edge; it then holds through RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp <= '0;
    end else if (state == ST_EXEC) begin
      rsp.id     <= opnd.id;
      rsp.zero   <= alu_zero;
      rsp.result <= alu_result;
    end
  end

  assign bus.Resp_Valid_o  = (state == ST_RESP);
  assign bus.Resp_Id_o     = rsp.id;
  assign bus.Resp_Result_o = rsp.result;
  assign bus.Resp_Zero_o   = rsp.zero;
  assign bus.Busy_o        = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: drives Resp_Ready_i low for a stretch to exercise the RESP hold.
module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // What the ALU must return, straight from the opcode table.
  function automatic exp_t spec_alu(input logic id, input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id = id;
    if (op == 4'b1000)      e.result = b << 12;
    else if (op == 4'b1001) e.result = a | b;
    else                    e.result = 32'd0;
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Model: -1 when idle, otherwise number of edges since the accept edge.
  int   m_age = -1;
  exp_t m_cur;
  logic m_ptr = 1'b0;
  bit   m_live = 1'b0;
  bit   m_after_rst = 1'b0;
  bit   d_rst = 1'b0;
  bit   d_acc = 1'b0;
  bit   d_hs  = 1'b0;
  logic d_id  = 1'b0;
  exp_t d_rec;
  exp_t hs_log[$];

  // Compare DUT against the model mid-cycle and decide what the next edge does.
  always @(negedge clk) begin : compare
    logic gid;
    logic e_r0;
    logic e_r1;
    exp_t seen;
    gid  = 1'b0;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (bus.Req0_Valid_i && bus.Req1_Valid_i) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      gid = m_ptr;
`else
      gid = 1'b0;
`endif
    end else begin
      gid = bus.Req1_Valid_i;
    end
    if (m_age < 0) begin
      e_r0 = bus.Req0_Valid_i && !gid;
      e_r1 = bus.Req1_Valid_i && gid;
    end
    if (m_live) begin
      chk("model_ready0", 32'(bus.Req0_Ready_o), 32'(e_r0));
      chk("model_ready1", 32'(bus.Req1_Ready_o), 32'(e_r1));
      chk("model_busy", 32'(bus.Busy_o), 32'(m_age >= 0));
      chk("model_resp_valid", 32'(bus.Resp_Valid_o), 32'(m_age >= 1));
      if (m_age >= 1) begin
        chk("model_resp_id", 32'(bus.Resp_Id_o), 32'(m_cur.id));
        chk("model_resp_result", bus.Resp_Result_o, m_cur.result);
        chk("model_resp_zero", 32'(bus.Resp_Zero_o), 32'(m_cur.zero));
      end
      if (m_after_rst) begin
        chk("reset_result", bus.Resp_Result_o, 32'd0);
        chk("reset_zero", 32'(bus.Resp_Zero_o), 32'd0);
        chk("reset_id", 32'(bus.Resp_Id_o), 32'd0);
      end
      if (bus.Resp_Valid_o && bus.Resp_Ready_i) begin
        seen.id     = bus.Resp_Id_o;
        seen.result = bus.Resp_Result_o;
        seen.zero   = bus.Resp_Zero_o;
        hs_log.push_back(seen);
      end
    end
    d_rst <= !reset;
    d_acc <= e_r0 || e_r1;
    d_id  <= gid;
    d_rec <= gid ? spec_alu(1'b1, bus.Req1_ALU_Operation_i, bus.Req1_A_i, bus.Req1_B_i)
                 : spec_alu(1'b0, bus.Req0_ALU_Operation_i, bus.Req0_A_i, bus.Req0_B_i);
    d_hs  <= (m_age >= 1) && bus.Resp_Ready_i;
  end

  // Advance the model on the clock edge.
  always @(posedge clk) begin : model
    cyc <= cyc + 1;
    m_after_rst <= d_rst;
    if (d_rst) begin
      m_age  <= -1;
      m_ptr  <= 1'b0;
      m_live <= 1'b1;
    end else if (m_age < 0) begin
      if (d_acc) begin
        m_age <= 0;
        m_cur <= d_rec;
        m_ptr <= !d_id;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (d_hs) begin
      m_age <= -1;
    end
  end

  task automatic drive(input bit port, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      bus.Req1_Valid_i = v; bus.Req1_ALU_Operation_i = op; bus.Req1_A_i = a; bus.Req1_B_i = b;
    end else begin
      bus.Req0_Valid_i = v; bus.Req0_ALU_Operation_i = op; bus.Req0_A_i = a; bus.Req0_B_i = b;
    end
  endtask

  // Present one request and hold it until Ready; returns the acceptance cycle.
  task automatic issue(input bit port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int acc_cyc);
    @(posedge clk); #1;
    drive(port, 1'b1, op, a, b);
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (port ? bus.Req1_Ready_o : bus.Req0_Ready_o) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, op, a, b);
  endtask

  task automatic wait_resp(output exp_t r, output int c);
    c = -1;
    r.id = 1'b0; r.result = 32'd0; r.zero = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.Resp_Valid_o && bus.Resp_Ready_i) begin
        r.id = bus.Resp_Id_o; r.result = bus.Resp_Result_o; r.zero = bus.Resp_Zero_o;
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_rsp(input string name, input exp_t r, input logic id,
                           input logic [31:0] res, input logic zero);
    chk({name, "_id"}, 32'(r.id), 32'(id));
    chk({name, "_result"}, r.result, res);
    chk({name, "_zero"}, 32'(r.zero), 32'(zero));
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.Busy_o) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t r;
    int   ac;
    int   rc;
    int   got0;
    logic exp_ids [4];
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    bus.Resp_Ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus.Resp_Valid_o), 32'd0);
    chk("rst_busy", 32'(bus.Busy_o), 32'd0);
    chk("rst_result", bus.Resp_Result_o, 32'd0);

    // LUI on port 0, with latency
    issue(1'b0, 4'b1000, 32'd0, 32'h0001_2345, ac);
    wait_resp(r, rc);
    chk("lui_latency", 32'(rc - ac), 32'd2);
    check_rsp("lui", r, 1'b0, 32'h1234_5000, 1'b0);

    // ORI on port 1
    issue(1'b1, 4'b1001, 32'h0000_00F0, 32'h0000_000F, ac);
    wait_resp(r, rc);
    check_rsp("ori", r, 1'b1, 32'h0000_00FF, 1'b0);

    // Unimplemented opcode
    issue(1'b0, 4'b0000, 32'd5, 32'd7, ac);
    wait_resp(r, rc);
    check_rsp("addi", r, 1'b0, 32'd0, 1'b1);

    // LUI whose low 20 bits of B are zero
    issue(1'b1, 4'b1000, 32'd0, 32'hFFF0_0000, ac);
    wait_resp(r, rc);
    check_rsp("lui_zero", r, 1'b1, 32'd0, 1'b1);

    // Contention after reset puts the pointer on port 0
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    hs_log.delete();
    drive(1'b0, 1'b1, 4'b1001, 32'h1, 32'h2);
    drive(1'b1, 1'b1, 4'b1001, 32'h10, 32'h20);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hs_log.size() >= 4) break;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'b1001, 32'h1, 32'h2);
    drive(1'b1, 1'b0, 4'b1001, 32'h10, 32'h20);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    chk("cont_count", 32'(hs_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_log.size()) begin
        chk("cont_id", 32'(hs_log[i].id), 32'(exp_ids[i]));
        chk("cont_result", hs_log[i].result, exp_ids[i] ? 32'h30 : 32'h3);
      end
    end
    wait_idle();

    // Backpressure: hold the response, with port 0 waiting behind it
    @(posedge clk); #1 bus.Resp_Ready_i = 1'b0;
    issue(1'b1, 4'b1001, 32'h0000_00A5, 32'h0000_05A0, ac);
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Resp_Valid_o) begin rc = 1; break; end
    end
    chk("bp_reach_resp", 32'(rc), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(1'b0, 1'b1, 4'b1000, 32'd0, 32'd1);
      @(negedge clk);
      chk("bp_result", bus.Resp_Result_o, 32'h0000_05A5);
      chk("bp_id", 32'(bus.Resp_Id_o), 32'd1);
      chk("bp_ready0", 32'(bus.Req0_Ready_o), 32'd0);
      chk("bp_ready1", 32'(bus.Req1_Ready_o), 32'd0);
      chk("bp_valid", 32'(bus.Resp_Valid_o), 32'd1);
    end
    hs_log.delete();
    @(posedge clk); #1 bus.Resp_Ready_i = 1'b1;
    got0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.Req0_Ready_o) got0 = 1;
      @(posedge clk); #1;
      if (got0 != 0) drive(1'b0, 1'b0, 4'b1000, 32'd0, 32'd1);
    end
    chk("bp_one_resp", 32'(hs_log.size()), 32'd1);
    if (hs_log.size() > 0) chk("bp_resp_id", 32'(hs_log[0].id), 32'd1);
    chk("bp_port0_accepted", 32'(got0), 32'd1);
    wait_resp(r, rc);
    check_rsp("bp_next", r, 1'b0, 32'h0000_1000, 1'b0);

    // Reset during EXEC drops the op
    issue(1'b0, 4'b1000, 32'd0, 32'h0000_0ABC, ac);
    reset = 1'b0;
    hs_log.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.Resp_Valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.Busy_o), 32'd0);
    chk("mid_rst_result", bus.Resp_Result_o, 32'd0);
    chk("mid_rst_zero", 32'(bus.Resp_Zero_o), 32'd0);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_resp", 32'(hs_log.size()), 32'd0);
    issue(1'b1, 4'b1001, 32'h0000_0100, 32'h0000_0001, ac);
    wait_resp(r, rc);
    check_rsp("post_rst", r, 1'b1, 32'h0000_0101, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
